// File: rtl/sddr_dev_pkg.sv
// Shared types for the DDR3 device-side responder.
// Command and error encodings, burst geometry, pipeline slot bundle.
package sddr_dev_pkg;

  localparam int BURST_LENGTH    = 8;
  localparam int BEATS_PER_CYCLE = 2;
  localparam int RAM_INDEX_BITS  = 8;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ACT_OPEN = 3'd1,
    ERR_CLOSED   = 3'd2,
    ERR_OVERLAP  = 3'd3,
    ERR_WD_MISS  = 3'd4,
    ERR_WD_STRAY = 3'd5
  } err_e;

  typedef struct packed {
    logic                      valid;
    logic                      is_read;
    logic [RAM_INDEX_BITS-1:0] ram_index;
    logic [1:0]                beat_idx;
  } burst_slot_t;

endpackage

// File: rtl/sddr_dev_responder_if.sv
// Controller/PHY command and data bundle seen by the device responder.
// master = controller side, slave = device side.
interface sddr_dev_responder_if #(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13,
  parameter int DATA_BITS = 16
);
  localparam int ADDR_BITS = ROW_BITS + $clog2(DATA_BITS/8);

  logic                      ctl_cs_n_i;
  logic                      ctl_ras_n_i;
  logic                      ctl_cas_n_i;
  logic                      ctl_we_n_i;
  logic [ADDR_BITS-1:0]      ctl_addr_i;
  logic [BANK_BITS-1:0]      ctl_ba_i;
  logic [1:0][DATA_BITS-1:0] ctl_dq_i;
  logic                      ctl_data_write_i;
  logic [1:0][DATA_BITS-1:0] dev_dq_o;
  logic                      dev_dq_valid_o;
  logic [2**BANK_BITS-1:0]   dev_bank_open_o;
  logic                      dev_error_o;
  logic [2:0]                dev_err_code_o;

  modport master (
    output ctl_cs_n_i, ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i,
    output ctl_addr_i, ctl_ba_i, ctl_dq_i, ctl_data_write_i,
    input  dev_dq_o, dev_dq_valid_o, dev_bank_open_o,
    input  dev_error_o, dev_err_code_o
  );

  modport slave (
    input  ctl_cs_n_i, ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i,
    input  ctl_addr_i, ctl_ba_i, ctl_dq_i, ctl_data_write_i,
    output dev_dq_o, dev_dq_valid_o, dev_bank_open_o,
    output dev_error_o, dev_err_code_o
  );

endinterface

// File: rtl/sddr_dev_burst_ram.sv
// Burst storage: one beat pair per word, four words per BL8 burst.
// Simple dual port, synchronous read, no reset on contents.
module sddr_dev_burst_ram #(
  parameter int DATA_BITS     = 16,
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [MEM_ADDR_BITS+1:0] waddr,
  input  logic [2*DATA_BITS-1:0]   wdata,
  input  logic                     re,
  input  logic [MEM_ADDR_BITS+1:0] raddr,
  output logic [2*DATA_BITS-1:0]   rdata
);

  logic [2*DATA_BITS-1:0] mem [(2**MEM_ADDR_BITS)*4];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sddr_dev_responder.sv
// DDR3 device model at the controller/PHY boundary: bank tracking,
// burst storage, read replay with CAS latency and command legality checks.
module sddr_dev_responder
  import sddr_dev_pkg::*;
#(
  parameter int BANK_BITS         = 3,
  parameter int ROW_BITS          = 13,
  parameter int COL_BITS          = 10,
  parameter int DATA_BITS         = 16,
  parameter int MEM_ADDR_BITS     = 8,
  parameter int CAS_LATENCY       = 6,
  parameter int CAS_WRITE_LATENCY = 5
) (
  input logic                 in_ddr_clock_i,
  input logic                 in_reset_i,
  sddr_dev_responder_if.slave bus
);

  localparam int NBANK     = 2**BANK_BITS;
  localparam int DEPTH     = CAS_LATENCY + 4;
  localparam int NPAIR     = BURST_LENGTH / BEATS_PER_CYCLE;
  localparam int ADDR_BITS = ROW_BITS + $clog2(DATA_BITS/8);

  logic [NBANK-1:0]          bank_open_q;
  logic [ROW_BITS-1:0]       row_q [NBANK];
  burst_slot_t               slot_q [DEPTH];
  logic                      rd_fire_q;
  logic                      valid_q;
  logic [1:0][DATA_BITS-1:0] dq_q;
  logic                      err_q;
  err_e                      code_q;
  logic [2*DATA_BITS-1:0]    rdata;

  cmd_e                      cmd;
  logic [BANK_BITS-1:0]      ba;
  logic                      a10;
  logic                      bank_hit;
  logic                      is_act;
  logic                      is_pre;
  logic                      is_rd;
  logic                      is_rw;
  logic [MEM_ADDR_BITS-1:0]  cmd_idx;
  logic                      rd_busy;
  logic                      wr_busy;
  logic                      acc_rd;
  logic                      acc_wr;
  logic                      wr_win;
  logic                      rd_issue;
  err_e                      cmd_err;
  err_e                      dat_err;
  err_e                      err_now;
  logic                      unused_addr;

  assign cmd = bus.ctl_cs_n_i ? CMD_NOP :
    cmd_e'({bus.ctl_ras_n_i, bus.ctl_cas_n_i, bus.ctl_we_n_i});

  assign ba       = bus.ctl_ba_i;
  assign a10      = bus.ctl_addr_i[10];
  assign bank_hit = bank_open_q[ba];
  assign is_act   = (cmd == CMD_ACT);
  assign is_pre   = (cmd == CMD_PRE);
  assign is_rd    = (cmd == CMD_RD);
  assign is_rw    = is_rd | (cmd == CMD_WR);

  assign unused_addr = ^bus.ctl_addr_i[ADDR_BITS-1:ROW_BITS];

  assign cmd_idx = MEM_ADDR_BITS'(
    {ba, row_q[ba], bus.ctl_addr_i[COL_BITS-1:3]});

  // slot_q[j] describes the data-window edge j+1 edges ahead
  always_comb begin
    rd_busy = 1'b0;
    wr_busy = 1'b0;
    for (int k = 0; k < NPAIR; k++) begin
      rd_busy = rd_busy | slot_q[CAS_LATENCY+k].valid;
      wr_busy = wr_busy | slot_q[CAS_WRITE_LATENCY+k].valid;
    end
  end

  always_comb begin
    cmd_err = ERR_NONE;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    unique case (1'b1)
      is_act: begin
        if (bank_hit) cmd_err = ERR_ACT_OPEN;
      end
      is_rw: begin
        if (!bank_hit) begin
          cmd_err = ERR_CLOSED;
        end else if (is_rd ? rd_busy : wr_busy) begin
          cmd_err = ERR_OVERLAP;
        end else begin
          acc_rd = is_rd;
          acc_wr = !is_rd;
        end
      end
      default: ;
    endcase
  end

  assign wr_win   = slot_q[0].valid && !slot_q[0].is_read;
  assign rd_issue = slot_q[1].valid && slot_q[1].is_read;

  always_comb begin
    dat_err = ERR_NONE;
    if (wr_win && !bus.ctl_data_write_i) dat_err = ERR_WD_MISS;
    else if (!wr_win && bus.ctl_data_write_i) dat_err = ERR_WD_STRAY;
  end

  assign err_now = (cmd_err != ERR_NONE) ? cmd_err : dat_err;

  // read is issued one slot early to cover the RAM read latency
  sddr_dev_burst_ram #(
    .DATA_BITS    (DATA_BITS),
    .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) u_ram (
    .clk  (in_ddr_clock_i),
    .we   (wr_win && bus.ctl_data_write_i && !in_reset_i),
    .waddr({MEM_ADDR_BITS'(slot_q[0].ram_index), slot_q[0].beat_idx}),
    .wdata(bus.ctl_dq_i),
    .re   (rd_issue),
    .raddr({MEM_ADDR_BITS'(slot_q[1].ram_index), slot_q[1].beat_idx}),
    .rdata(rdata)
  );

  always_ff @(posedge in_ddr_clock_i) begin
    if (in_reset_i) begin
      bank_open_q <= '0;
      for (int b = 0; b < NBANK; b++) row_q[b] <= '0;
      for (int j = 0; j < DEPTH; j++) slot_q[j] <= '0;
      rd_fire_q <= 1'b0;
      valid_q   <= 1'b0;
      dq_q      <= '0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      for (int j = 0; j < DEPTH-1; j++) slot_q[j] <= slot_q[j+1];
      slot_q[DEPTH-1] <= '0;
      if (acc_rd) begin
        for (int k = 0; k < NPAIR; k++)
          slot_q[CAS_LATENCY-1+k] <= '{valid: 1'b1, is_read: 1'b1,
            ram_index: RAM_INDEX_BITS'(cmd_idx), beat_idx: 2'(k)};
      end
      if (acc_wr) begin
        for (int k = 0; k < NPAIR; k++)
          slot_q[CAS_WRITE_LATENCY-1+k] <= '{valid: 1'b1, is_read: 1'b0,
            ram_index: RAM_INDEX_BITS'(cmd_idx), beat_idx: 2'(k)};
      end
      if (is_act && !bank_hit) begin
        bank_open_q[ba] <= 1'b1;
        row_q[ba]       <= bus.ctl_addr_i[ROW_BITS-1:0];
      end
      if (is_pre) begin
        if (a10) bank_open_q <= '0;
        else     bank_open_q[ba] <= 1'b0;
      end
      if ((acc_rd || acc_wr) && a10) bank_open_q[ba] <= 1'b0;
      rd_fire_q <= rd_issue;
      valid_q   <= rd_fire_q;
      dq_q      <= rd_fire_q ? rdata : '0;
      if (!err_q && err_now != ERR_NONE) begin
        err_q  <= 1'b1;
        code_q <= err_now;
      end
    end
  end

  assign bus.dev_dq_o        = dq_q;
  assign bus.dev_dq_valid_o  = valid_q;
  assign bus.dev_bank_open_o = bank_open_q;
  assign bus.dev_error_o     = err_q;
  assign bus.dev_err_code_o  = code_q;

endmodule

// File: tb/tb_sddr_dev_responder.sv
// Directed bench for sddr_dev_responder: bank state, burst storage,
// read timing, spacing and error reporting.
module tb_sddr_dev_responder;
  import sddr_dev_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  logic        cap_v [16];
  logic [31:0] cap_d [16];
  logic [7:0]  cap_open;

  sddr_dev_responder_if bus ();

  sddr_dev_responder dut (
    .in_ddr_clock_i(clk),
    .in_reset_i    (rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    bus.ctl_cs_n_i  = 1'b1;
    bus.ctl_ras_n_i = 1'b1;
    bus.ctl_cas_n_i = 1'b1;
    bus.ctl_we_n_i  = 1'b1;
    bus.ctl_addr_i  = '0;
    bus.ctl_ba_i    = '0;
  endtask

  task automatic set_cmd(input cmd_e c, input logic [2:0] ba,
                         input logic [13:0] a);
    bus.ctl_cs_n_i = 1'b0;
    {bus.ctl_ras_n_i, bus.ctl_cas_n_i, bus.ctl_we_n_i} = c;
    bus.ctl_ba_i   = ba;
    bus.ctl_addr_i = a;
  endtask

  task automatic drive_cmd(input cmd_e c, input logic [2:0] ba,
                           input logic [13:0] a);
    set_cmd(c, ba, a);
    step();
    set_nop();
  endtask

  task automatic do_reset();
    set_nop();
    bus.ctl_data_write_i = 1'b0;
    bus.ctl_dq_i = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr_burst(input logic [2:0] ba, input logic [13:0] a,
                          input int base, input int skip);
    drive_cmd(CMD_WR, ba, a);
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      bus.ctl_data_write_i = (k != skip);
      bus.ctl_dq_i[0] = 16'(base + 2*k);
      bus.ctl_dq_i[1] = 16'(base + 2*k + 1);
      step();
    end
    bus.ctl_data_write_i = 1'b0;
    bus.ctl_dq_i = '0;
  endtask

  task automatic capture_rd(input logic [2:0] ba, input logic [13:0] a0,
                            input int off, input logic [13:0] a1);
    drive_cmd(CMD_RD, ba, a0);
    cap_open = bus.dev_bank_open_o;
    cap_v[0] = bus.dev_dq_valid_o;
    cap_d[0] = bus.dev_dq_o;
    for (int i = 1; i < 16; i++) begin
      if (i == off) set_cmd(CMD_RD, ba, a1);
      step();
      set_nop();
      cap_v[i] = bus.dev_dq_valid_o;
      cap_d[i] = bus.dev_dq_o;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.dev_dq_valid_o !== 1'b0 || bus.dev_dq_o !== '0) begin
      miscompares++;
      $display("FAIL reset_dq: valid=%b dq=%h want 0/0",
               bus.dev_dq_valid_o, bus.dev_dq_o);
    end
    vectors++;
    if (bus.dev_bank_open_o !== 8'h00 || bus.dev_error_o !== 1'b0 ||
        bus.dev_err_code_o !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: open=%h err=%b code=%0d want 0/0/0",
               bus.dev_bank_open_o, bus.dev_error_o, bus.dev_err_code_o);
    end
  endtask

  task automatic test_write_read();
    logic ev;
    logic [31:0] ed;
    drive_cmd(CMD_ACT, 3'd2, 14'h0123);
    wr_burst(3'd2, 14'h0000, 1, 4);
    capture_rd(3'd2, 14'h0000, 0, 14'h0000);
    for (int i = 1; i < 16; i++) begin
      ev = (i >= 6 && i <= 9);
      ed = ev ? {16'(2*(i-6) + 2), 16'(2*(i-6) + 1)} : 32'h0;
      vectors++;
      if (cap_v[i] !== ev || cap_d[i] !== ed) begin
        miscompares++;
        $display("FAIL wr_rd[%0d]: valid=%b dq=%h want %b/%h",
                 i, cap_v[i], cap_d[i], ev, ed);
      end
    end
    vectors++;
    if (bus.dev_bank_open_o !== 8'h04 || bus.dev_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_rd_open: open=%h err=%b want 04/0",
               bus.dev_bank_open_o, bus.dev_error_o);
    end
  endtask

  task automatic test_closed_bank();
    int nv;
    capture_rd(3'd3, 14'h0000, 0, 14'h0000);
    nv = 0;
    for (int i = 0; i < 16; i++) if (cap_v[i] !== 1'b0) nv++;
    vectors++;
    if (nv != 0) begin
      miscompares++;
      $display("FAIL closed_valid: %0d valid cycles want 0", nv);
    end
    vectors++;
    if (bus.dev_error_o !== 1'b1 || bus.dev_err_code_o !== 3'd2) begin
      miscompares++;
      $display("FAIL closed_err: err=%b code=%0d want 1/2",
               bus.dev_error_o, bus.dev_err_code_o);
    end
  endtask

  task automatic test_act_twice();
    logic [31:0] ed;
    do_reset();
    drive_cmd(CMD_ACT, 3'd1, 14'h0AAA);
    wr_burst(3'd1, 14'h0000, 'h40, 4);
    drive_cmd(CMD_ACT, 3'd1, 14'h0555);
    vectors++;
    if (bus.dev_error_o !== 1'b1 || bus.dev_err_code_o !== 3'd1) begin
      miscompares++;
      $display("FAIL act_twice_err: err=%b code=%0d want 1/1",
               bus.dev_error_o, bus.dev_err_code_o);
    end
    drive_cmd(CMD_ACT, 3'd4, 14'h0000);
    vectors++;
    if (bus.dev_bank_open_o !== 8'h12) begin
      miscompares++;
      $display("FAIL act_open: open=%h want 12", bus.dev_bank_open_o);
    end
    capture_rd(3'd1, 14'h0000, 0, 14'h0000);
    for (int i = 6; i <= 9; i++) begin
      ed = {16'('h40 + 2*(i-6) + 1), 16'('h40 + 2*(i-6))};
      vectors++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== ed) begin
        miscompares++;
        $display("FAIL act_row_kept[%0d]: valid=%b dq=%h want 1/%h",
                 i, cap_v[i], cap_d[i], ed);
      end
    end
    drive_cmd(CMD_PRE, 3'd0, 14'h0400);
    vectors++;
    if (bus.dev_bank_open_o !== 8'h00) begin
      miscompares++;
      $display("FAIL pre_all: open=%h want 00", bus.dev_bank_open_o);
    end
  endtask

  task automatic test_back_to_back();
    logic ev;
    logic [31:0] ed;
    do_reset();
    drive_cmd(CMD_ACT, 3'd0, 14'h0000);
    wr_burst(3'd0, 14'h0000, 'h100, 4);
    wr_burst(3'd0, 14'h0008, 'h200, 4);
    capture_rd(3'd0, 14'h0000, 4, 14'h0008);
    for (int i = 1; i < 16; i++) begin
      ev = (i >= 6 && i <= 13);
      if (i >= 6 && i <= 9)
        ed = {16'('h100 + 2*(i-6) + 1), 16'('h100 + 2*(i-6))};
      else if (i >= 10 && i <= 13)
        ed = {16'('h200 + 2*(i-10) + 1), 16'('h200 + 2*(i-10))};
      else
        ed = 32'h0;
      vectors++;
      if (cap_v[i] !== ev || cap_d[i] !== ed) begin
        miscompares++;
        $display("FAIL b2b[%0d]: valid=%b dq=%h want %b/%h",
                 i, cap_v[i], cap_d[i], ev, ed);
      end
    end
    vectors++;
    if (bus.dev_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_err: err=%b want 0", bus.dev_error_o);
    end
    capture_rd(3'd0, 14'h0000, 2, 14'h0008);
    for (int i = 1; i < 16; i++) begin
      ev = (i >= 6 && i <= 9);
      ed = ev ? {16'('h100 + 2*(i-6) + 1), 16'('h100 + 2*(i-6))} : 32'h0;
      vectors++;
      if (cap_v[i] !== ev || cap_d[i] !== ed) begin
        miscompares++;
        $display("FAIL close_rd[%0d]: valid=%b dq=%h want %b/%h",
                 i, cap_v[i], cap_d[i], ev, ed);
      end
    end
    vectors++;
    if (bus.dev_error_o !== 1'b1 || bus.dev_err_code_o !== 3'd3) begin
      miscompares++;
      $display("FAIL overlap_err: err=%b code=%0d want 1/3",
               bus.dev_error_o, bus.dev_err_code_o);
    end
  endtask

  task automatic test_wdata_gap();
    logic [31:0] ed;
    int b;
    do_reset();
    drive_cmd(CMD_ACT, 3'd0, 14'h0000);
    wr_burst(3'd0, 14'h0010, 'h300, 4);
    vectors++;
    if (bus.dev_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_pre_err: err=%b want 0", bus.dev_error_o);
    end
    wr_burst(3'd0, 14'h0010, 'h500, 2);
    vectors++;
    if (bus.dev_error_o !== 1'b1 || bus.dev_err_code_o !== 3'd4) begin
      miscompares++;
      $display("FAIL gap_err: err=%b code=%0d want 1/4",
               bus.dev_error_o, bus.dev_err_code_o);
    end
    capture_rd(3'd0, 14'h0010, 0, 14'h0000);
    for (int i = 6; i <= 9; i++) begin
      b = (i == 8) ? 'h300 : 'h500;
      ed = {16'(b + 2*(i-6) + 1), 16'(b + 2*(i-6))};
      vectors++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== ed) begin
        miscompares++;
        $display("FAIL gap_rd[%0d]: valid=%b dq=%h want 1/%h",
                 i, cap_v[i], cap_d[i], ed);
      end
    end
  endtask

  task automatic test_stray_write();
    do_reset();
    bus.ctl_data_write_i = 1'b1;
    step();
    bus.ctl_data_write_i = 1'b0;
    step();
    vectors++;
    if (bus.dev_error_o !== 1'b1 || bus.dev_err_code_o !== 3'd5) begin
      miscompares++;
      $display("FAIL stray_err: err=%b code=%0d want 1/5",
               bus.dev_error_o, bus.dev_err_code_o);
    end
  endtask

  task automatic test_auto_precharge();
    logic [31:0] ed;
    do_reset();
    drive_cmd(CMD_ACT, 3'd5, 14'h0010);
    wr_burst(3'd5, 14'h0000, 'h700, 4);
    vectors++;
    if (bus.dev_bank_open_o !== 8'h20) begin
      miscompares++;
      $display("FAIL ap_open_pre: open=%h want 20", bus.dev_bank_open_o);
    end
    capture_rd(3'd5, 14'h0400, 0, 14'h0000);
    vectors++;
    if (cap_open !== 8'h00) begin
      miscompares++;
      $display("FAIL ap_close: open=%h want 00", cap_open);
    end
    for (int i = 6; i <= 9; i++) begin
      ed = {16'('h700 + 2*(i-6) + 1), 16'('h700 + 2*(i-6))};
      vectors++;
      if (cap_v[i] !== 1'b1 || cap_d[i] !== ed) begin
        miscompares++;
        $display("FAIL ap_rd[%0d]: valid=%b dq=%h want 1/%h",
                 i, cap_v[i], cap_d[i], ed);
      end
    end
    vectors++;
    if (bus.dev_error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ap_err: err=%b want 0", bus.dev_error_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive_cmd(CMD_ACT, 3'd0, 14'h0000);
    drive_cmd(CMD_RD, 3'd0, 14'h0000);
    repeat (6) step();
    vectors++;
    if (bus.dev_dq_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_valid: valid=%b want 1", bus.dev_dq_valid_o);
    end
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (bus.dev_dq_valid_o !== 1'b0 || bus.dev_dq_o !== '0 ||
        bus.dev_bank_open_o !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b dq=%h open=%h want 0/0/00",
               bus.dev_dq_valid_o, bus.dev_dq_o, bus.dev_bank_open_o);
    end
    rst = 1'b0;
    step();
    step();
    vectors++;
    if (bus.dev_dq_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_flush: valid=%b want 0", bus.dev_dq_valid_o);
    end
  endtask

  initial begin
    set_nop();
    bus.ctl_data_write_i = 1'b0;
    bus.ctl_dq_i = '0;
    test_reset();
    test_write_read();
    test_closed_bank();
    test_act_twice();
    test_back_to_back();
    test_wdata_gap();
    test_stray_write();
    test_auto_precharge();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sddr_dev_responder.md
Name: sddr_dev_responder

Overview:
- Synthesizable DDR3 device-side responder at the controller/PHY command interface, in the DDR clock domain.
- Consumes the same ctl_* command and write-data signals the controller drives into the PHY, and returns read bursts as the device would.
- Used for controller bring-up and loopback regression without a physical DDR3 part.
- Tracks per-bank open rows, stores write bursts in a small internal RAM, checks command legality.

Parameters:
- BANK_BITS, 3, bank address width
- ROW_BITS, 13, row address width; address bus is ROW_BITS+$clog2(DATA_BITS/8)
- COL_BITS, 10, column address width
- DATA_BITS, 16, DQ width
- MEM_ADDR_BITS, 8, internal RAM depth log2, in bursts
- CAS_LATENCY, 6, cycles from RD to first read beat pair
- CAS_WRITE_LATENCY, 5, cycles from WR to first write beat pair

Ports:
- in_ddr_clock_i  in  1  sole clock
- in_reset_i  in  1  synchronous reset, active-high
- ctl_cs_n_i  in  1  chip select, active low
- ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i  in  1 each  command
- ctl_addr_i  in  ROW_BITS+$clog2(DATA_BITS/8)  row/column address; bit 10 = A10
- ctl_ba_i  in  BANK_BITS  bank
- ctl_dq_i[1:0]  in  DATA_BITS each  write beat pair, [0] first
- ctl_data_write_i  in  1  write data valid this cycle
- dev_dq_o[1:0]  out  DATA_BITS each  read beat pair, [0] first
- dev_dq_valid_o  out  1  read pair valid
- dev_bank_open_o  out  2**BANK_BITS  per-bank open flag
- dev_error_o  out  1  sticky error
- dev_err_code_o  out  3  first error cause

Behaviour:
- Reset, all outputs: dev_dq_o=0, valid=0, bank_open=0, error=0, err_code=0. Pending bursts are flushed. RAM contents are undefined.
- Command sampling:
  - One command per cycle, sampled on the posedge when cs_n=0; cs_n=1 means NOP.
  - {ras,cas,we} decode: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ, 111 NOP.
  - MRS, REF and ZQ are accepted and have no effect.
- ACT: sets bank_open[ba] and latches row[ba]=addr[ROW_BITS-1:0]. ACT to an already-open bank is error code 1; the row is not changed.
- PRE: A10=1 clears all banks. A10=0 clears bank ba. PRE to a closed bank is legal.
- RD/WR:
  - Bank must be open, else error code 2 and the command is dropped.
  - RAM index = {ba, row[ba], col[COL_BITS-1:3]}, truncated to the low MEM_ADDR_BITS.
  - col[2:0] is ignored; bursts are always aligned BL8.
  - A10=1 means auto-precharge: the bank closes when the command is accepted.
- Burst spacing:
  - A BL8 burst occupies 4 cycles of 2 beats.
  - A RD or WR whose data window overlaps a previously accepted burst's window of either type is error code 3 and is dropped.
  - Back-to-back at 4-cycle spacing is legal, giving continuous valid.
- Read pipeline:
  - An accepted RD schedules a 4-cycle output starting exactly CAS_LATENCY cycles after the command edge.
  - Pair k (k=0..3) = beats 2k and 2k+1 of the stored burst.
  - dev_dq_valid_o is high for exactly those 4 cycles; dev_dq_o=0 when not valid.
  - Use a slot shift register of depth CAS_LATENCY+4.
- Write pipeline:
  - An accepted WR expects ctl_data_write_i=1 on cycles CAS_WRITE_LATENCY..+3 after the command.
  - Each pair is stored on its cycle.
  - data_write=0 inside the window is error code 4; that pair is not stored.
  - data_write=1 outside any window is error code 5 and is ignored.
- Read-after-write to the same index: a RD issued after the WR's last pair sees the new data. Bypass is not required; the spacing rule already guarantees this.
- Error reporting: dev_error_o sets on the first error and holds until reset. err_code keeps the first cause. Simultaneous causes: lowest code wins.
- Reset mid-burst: output is valid=0 on the next cycle and pending writes are discarded.

Decomposition:
- Package sddr_dev_pkg holds:
  - cmd_e enum for the 8 commands;
  - err_e codes 0..5;
  - BURST_LENGTH=8 and BEATS_PER_CYCLE=2;
  - burst_slot_t struct {valid, is_read, ram_index, beat_idx}.
- One sub-module, sddr_dev_burst_ram: simple dual-port, 1 write/1 read port, synchronous read, DATA_BITS*2 wide, (2**MEM_ADDR_BITS)*4 deep.
- Account for its 1-cycle read latency by issuing the read one slot early.

Test Plan:
- Reset, ACT ba=2 row=0x0123, WR col=0 with pairs {1,2},{3,4},{5,6},{7,8} at +5 cycles, then RD col=0 -> valid exactly cycles +6..+9 after RD, pairs 1..8 in order; bank_open=0x04.
- RD to closed bank 3 -> error=1, err_code=2, no valid.
- ACT ba=1 twice -> err_code=1; row stays at the first value. PRE A10=1 -> bank_open=0.
- Two RDs 4 cycles apart to two written bursts -> 8 continuous valid cycles; RDs 2 cycles apart -> second dropped, err_code=3.
- WR with data_write low on pair 2 -> err_code=4; later RD returns pair 2 as stale RAM data and other pairs as written.
- RD with auto-precharge (A10=1) -> data returned, bank_open bit clears next cycle. Reset asserted during read window -> valid=0 next cycle.
